// File: rtl/array_mult_stream_pkg.sv
// mult_pkg: shared helpers for the elastic array multiplier
package mult_pkg;
  function automatic int rows_per_stage(int w, int s);
    return w / s;
  endfunction
  function automatic bit stages_legal(int w, int s);
    return w >= 2 && s >= 1 && s <= w && w % s == 0;
  endfunction
endpackage

// File: rtl/array_mult_stream_if.sv
// array_mult_stream_if: operand/result streams with valid/ready on both sides
interface array_mult_stream_if #(
  parameter int WIDTH = 8,
  parameter int CONTROL_SIGNALS_WIDTH = 4
);
  logic [WIDTH-1:0] x, y;
  logic signed_mode;
  logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls_in, ctrls_out;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [2*WIDTH-1:0] result;
  modport master (
    output x, y, signed_mode, ctrls_in, in_valid, out_ready,
    input in_ready, result, ctrls_out, out_valid
  );
  modport slave (
    input x, y, signed_mode, ctrls_in, in_valid, out_ready,
    output in_ready, result, ctrls_out, out_valid
  );
endinterface

// File: rtl/array_mult_stream_stage.sv
// mult_stage: adds R partial-product rows into the running sum and registers the stage record
module mult_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int R = 2,
  parameter int FIRST_ROW = 0,
  parameter int CONTROL_SIGNALS_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic v_i,
  input  logic sm_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [2*WIDTH-1:0] sum_i,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls_i,
  output logic v_o,
  output logic sm_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [2*WIDTH-1:0] sum_o,
  output logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls_o
);
  localparam int PW = 2 * WIDTH;
  localparam bit LAST = (FIRST_ROW + R) == WIDTH;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] CORR = (ONE << WIDTH) | (ONE << (PW - 1));
  typedef struct packed {
    logic v;
    logic sm;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [PW-1:0] sum;
    logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls;
  } rec_t;
  rec_t rec_d, rec_q;
  logic [PW-1:0] rows;
  // Baugh-Wooley rows: signed mode inverts bits pairing exactly one sign bit; the stage holding row WIDTH-1 adds 2^W + 2^(2W-1)
  always_comb begin
    rows = (LAST && sm_i) ? CORR : '0;
    for (int i = FIRST_ROW; i < FIRST_ROW + R; i++)
      for (int j = 0; j < WIDTH; j++)
        rows = rows + (PW'((x_i[j] & y_i[i]) ^ (sm_i & ((i == WIDTH - 1) != (j == WIDTH - 1)))) << (i + j));
    rec_d = adv ? rec_t'{v_i, sm_i, x_i, y_i, sum_i + rows, ctrls_i} : rec_q;
  end
  // stage record: loads from upstream when the stage advances, otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rec_q <= '0;
    else rec_q <= rec_d;
  end
  assign v_o = rec_q.v;
  assign sm_o = rec_q.sm;
  assign x_o = rec_q.x;
  assign y_o = rec_q.y;
  assign sum_o = rec_q.sum;
  assign ctrls_o = rec_q.ctrls;
endmodule

// File: rtl/array_mult_stream.sv
// array_mult_stream: elastic pipelined signed/unsigned array multiplier with sideband
module array_mult_stream
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGES = 4,
  parameter int CONTROL_SIGNALS_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  array_mult_stream_if.slave bus
);
  localparam int R = rows_per_stage(WIDTH, STAGES);
  localparam int PW = 2 * WIDTH;
  if (!stages_legal(WIDTH, STAGES) || CONTROL_SIGNALS_WIDTH < 1) begin : g_bad_params
    $error("array_mult_stream: illegal WIDTH/STAGES/CONTROL_SIGNALS_WIDTH combination");
  end
  logic [STAGES:0] v, sm, adv;
  logic [WIDTH-1:0] xs [STAGES+1];
  logic [WIDTH-1:0] ys [STAGES+1];
  logic [PW-1:0] sums [STAGES+1];
  logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls [STAGES+1];
  assign v[0] = bus.in_valid;
  assign sm[0] = bus.signed_mode;
  assign xs[0] = bus.x;
  assign ys[0] = bus.y;
  assign sums[0] = '0;
  assign ctrls[0] = bus.ctrls_in;
  // advance chain from the tail: a stage moves when it is empty or its successor moves
  always_comb begin
    adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) adv[k] = !v[k+1] || adv[k+1];
  end
  assign bus.in_ready = adv[0] && !rst;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    mult_stage #(
      .WIDTH(WIDTH),
      .R(R),
      .FIRST_ROW(s * R),
      .CONTROL_SIGNALS_WIDTH(CONTROL_SIGNALS_WIDTH)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .adv(adv[s]),
      .v_i(v[s]),
      .sm_i(sm[s]),
      .x_i(xs[s]),
      .y_i(ys[s]),
      .sum_i(sums[s]),
      .ctrls_i(ctrls[s]),
      .v_o(v[s+1]),
      .sm_o(sm[s+1]),
      .x_o(xs[s+1]),
      .y_o(ys[s+1]),
      .sum_o(sums[s+1]),
      .ctrls_o(ctrls[s+1])
    );
  end
  assign bus.out_valid = v[STAGES];
  assign bus.result = sums[STAGES];
  assign bus.ctrls_out = ctrls[STAGES];
endmodule

// File: tb/tb_array_mult_stream.sv
// tb_array_mult_stream: directed and scoreboarded checks of the elastic multiplier
module tb_array_mult_stream;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  array_mult_stream_if #(8, 4) b8();
  array_mult_stream_if #(4, 1) b1();
  array_mult_stream_if #(4, 1) b2();
  array_mult_stream_if #(4, 1) b4();
  array_mult_stream #(.WIDTH(8), .STAGES(4), .CONTROL_SIGNALS_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(b8));
  array_mult_stream #(.WIDTH(4), .STAGES(1), .CONTROL_SIGNALS_WIDTH(1)) dut_s1 (.clk(clk), .rst(rst), .bus(b1));
  array_mult_stream #(.WIDTH(4), .STAGES(2), .CONTROL_SIGNALS_WIDTH(1)) dut_s2 (.clk(clk), .rst(rst), .bus(b2));
  array_mult_stream #(.WIDTH(4), .STAGES(4), .CONTROL_SIGNALS_WIDTH(1)) dut_s4 (.clk(clk), .rst(rst), .bus(b4));

  int passed = 0, total = 0, ncyc = 0, nin = 0, nout = 0, lat = 0, guard = 0;
  int first_in = -1, first_out = -1, last_out = -1;
  logic [19:0] q[$];
  logic [15:0] cur_exp, hold;
  logic [7:0] ra, rb;
  logic [7:0] exp4 [512];
  logic [7:0] vx [8] = '{8'd0, 8'd128, 8'd255, 8'd255, 8'd255, 8'd127, 8'd127, 8'd3};
  logic [7:0] vy [8] = '{8'd200, 8'd128, 8'd255, 8'd5, 8'd5, 8'd128, 8'd128, 8'd3};
  logic vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] vexp [8] = '{16'h0000, 16'h4000, 16'hFE01, 16'hFFFB, 16'h04FB, 16'hC080, 16'h3F80, 16'h0009};

  function automatic logic [15:0] ref_mul(int w, logic [7:0] a, logic [7:0] b, logic sm);
    longint sa = longint'(a);
    longint sb = longint'(b);
    if (sm && a[w-1]) sa -= longint'(1) << w;
    if (sm && b[w-1]) sb -= longint'(1) << w;
    return 16'((sa * sb) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(logic [7:0] a, logic [7:0] b, logic sm, logic [3:0] c, logic [15:0] e);
    b8.x = a;
    b8.y = b;
    b8.signed_mode = sm;
    b8.ctrls_in = c;
    cur_exp = e;
    b8.in_valid = 1;
  endtask

  // one clock: record input transfers, score output transfers, advance
  task automatic cyc();
    @(negedge clk);
    if (b8.in_valid && b8.in_ready) begin
      q.push_back({b8.ctrls_in, cur_exp});
      nin++;
      if (first_in < 0) first_in = ncyc;
    end
    if (b8.out_valid && b8.out_ready) begin
      chk("scoreboard", {1'b1, b8.ctrls_out, b8.result}, (q.size() != 0) ? {1'b1, q.pop_front()} : 21'h0);
      nout++;
      if (first_out < 0) first_out = ncyc;
      last_out = ncyc;
    end
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  initial begin
    b8.x = 0; b8.y = 0; b8.signed_mode = 0; b8.ctrls_in = 0; b8.in_valid = 0; b8.out_ready = 1;
    b1.x = 0; b1.y = 0; b1.signed_mode = 0; b1.ctrls_in = 0; b1.in_valid = 0; b1.out_ready = 1;
    b2.x = 0; b2.y = 0; b2.signed_mode = 0; b2.ctrls_in = 0; b2.in_valid = 0; b2.out_ready = 1;
    b4.x = 0; b4.y = 0; b4.signed_mode = 0; b4.ctrls_in = 0; b4.in_valid = 0; b4.out_ready = 1;
    cur_exp = 0;
    #1 rst = 1;
    #1;
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_result", b8.result, 0);
    chk("rst_ctrls_out", b8.ctrls_out, 0);
    chk("rst_in_ready", b8.in_ready, 0);
    @(posedge clk);
    #1 rst = 0;

    drive(8'd255, 8'd255, 1'b0, 4'hA, 16'hFE01);
    @(negedge clk);
    chk("lat_in_ready", b8.in_ready, 1);
    @(posedge clk);
    #1 b8.in_valid = 0;
    lat = 1;
    while (!b8.out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, 4);
    chk("lat_result", b8.result, 16'hFE01);
    chk("lat_ctrls", b8.ctrls_out, 4'hA);
    @(posedge clk);
    #1;
    chk("lat_no_dup", b8.out_valid, 0);

    nout = 0;
    for (int i = 0; i < 8; i++) begin
      drive(vx[i], vy[i], vs[i], 4'(i), vexp[i]);
      cyc();
    end
    b8.in_valid = 0;
    repeat (8) cyc();
    chk("mixed_count", nout, 8);

    nout = 0; first_in = -1; first_out = -1; last_out = -1;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      drive(ra, rb, i[0], 4'(i), ref_mul(8, ra, rb, i[0]));
      cyc();
    end
    b8.in_valid = 0;
    repeat (8) cyc();
    chk("stream_count", nout, 16);
    chk("stream_first_lat", first_out - first_in, 4);
    chk("stream_consecutive", last_out - first_out, 15);

    b8.out_ready = 0;
    nin = 0;
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      drive(ra, rb, i[1], 4'(i + 3), ref_mul(8, ra, rb, i[1]));
      cyc();
    end
    chk("bp_accepted", nin, 4);
    chk("bp_in_ready", b8.in_ready, 0);
    chk("bp_out_valid", b8.out_valid, 1);
    hold = b8.result;
    repeat (3) cyc();
    chk("bp_hold", b8.result, hold);
    chk("bp_head", {b8.ctrls_out, b8.result}, q[0]);
    b8.in_valid = 0;
    b8.out_ready = 1;
    nout = 0;
    repeat (10) cyc();
    chk("bp_drain", nout, 4);
    chk("bp_queue_empty", q.size(), 0);

    nin = 0; nout = 0; guard = 0;
    while (nin < 1000 && guard < 5000) begin
      b8.out_ready = 1'($urandom_range(0, 1));
      ra = 8'($urandom); rb = 8'($urandom);
      drive(ra, rb, 1'($urandom), 4'($urandom), 16'h0);
      cur_exp = ref_mul(8, ra, rb, b8.signed_mode);
      cyc();
      guard++;
    end
    b8.in_valid = 0;
    b8.out_ready = 1;
    repeat (10) cyc();
    chk("rand_in", nin, 1000);
    chk("rand_out", nout, 1000);

    b8.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(8'(200 + i), 8'd100, 1'b0, 4'hF, ref_mul(8, 8'(200 + i), 8'd100, 1'b0));
      cyc();
    end
    b8.in_valid = 0;
    cyc();
    chk("pre_rst_valid", b8.out_valid, 1);
    #2 rst = 1;
    #1;
    chk("midrst_out_valid", b8.out_valid, 0);
    chk("midrst_result", b8.result, 0);
    chk("midrst_ctrls", b8.ctrls_out, 0);
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    b8.out_ready = 1;
    nout = 0;
    drive(8'd3, 8'd3, 1'b0, 4'h5, 16'h0009);
    cyc();
    b8.in_valid = 0;
    repeat (8) cyc();
    chk("rst_fresh_count", nout, 1);

    for (int k = 0; k < 516; k++) begin
      if (k < 512) begin
        exp4[k] = 8'(ref_mul(4, {4'b0, 4'(k)}, {4'b0, 4'(k >> 4)}, k[8]));
        b1.x = 4'(k); b1.y = 4'(k >> 4); b1.signed_mode = k[8]; b1.ctrls_in = k[0]; b1.in_valid = 1;
        b2.x = 4'(k); b2.y = 4'(k >> 4); b2.signed_mode = k[8]; b2.ctrls_in = k[0]; b2.in_valid = 1;
        b4.x = 4'(k); b4.y = 4'(k >> 4); b4.signed_mode = k[8]; b4.ctrls_in = k[0]; b4.in_valid = 1;
      end else begin
        b1.in_valid = 0; b2.in_valid = 0; b4.in_valid = 0;
      end
      @(negedge clk);
      if (k >= 1 && k - 1 < 512) chk("sweep_s1", {b1.out_valid, b1.result}, {1'b1, exp4[k-1]});
      if (k >= 2 && k - 2 < 512) chk("sweep_s2", {b2.out_valid, b2.result}, {1'b1, exp4[k-2]});
      if (k >= 4 && k - 4 < 512) chk("sweep_s4", {b4.out_valid, b4.result}, {1'b1, exp4[k-4]});
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
